// File: rtl/sr_cmd_debouncer.sv
// Two-channel synchronise/debounce/edge-detect front end driving an SR flip-flop's S and R.
// Optional macro SR_RESET_PRIORITY_EN: reset wins a simultaneous qualify instead of both being suppressed.
module sr_cmd_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic reset_btn,
    output logic S,
    output logic R,
    output logic set_level,
    output logic reset_level,
    output logic conflict
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Channel index 0 is set, index 1 is reset.
    logic [1:0]         raw;
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         level;
    logic [1:0]         level_nxt;
    logic [1:0]         rise;
    logic [1:0][CW-1:0] cnt;
    logic [1:0][CW-1:0] cnt_nxt;
    logic               s_q;
    logic               r_q;
    logic               conflict_q;
    logic               s_nxt;
    logic               r_nxt;
    logic               conflict_nxt;

    assign raw = {reset_btn, set_btn};

    // A single agreeing sample clears the count, so only an unbroken run qualifies.
    always_comb begin
        level_nxt = level;
        rise      = '0;
        cnt_nxt   = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2[i] != level[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    level_nxt[i] = sync2[i];
                    rise[i]      = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        s_nxt        = rise[0] & ~rise[1];
        conflict_nxt = rise[0] & rise[1];
`ifdef SR_RESET_PRIORITY_EN
        r_nxt        = rise[1];
`else
        r_nxt        = rise[1] & ~rise[0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            level      <= '0;
            cnt        <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            level      <= level_nxt;
            cnt        <= cnt_nxt;
            s_q        <= s_nxt;
            r_q        <= r_nxt;
            conflict_q <= conflict_nxt;
        end
    end

    assign S           = s_q;
    assign R           = r_q;
    assign conflict    = conflict_q;
    assign set_level   = level[0];
    assign reset_level = level[1];

endmodule
